// File: rtl/clk_div_prog_pkg.sv
// Shared constants and types for the programmable clock divider.
//   CDP_DIV_W    : width of the half-period field (shared divider-width constant)
//   CDP_RST_HALF : half-period minus one loaded at reset (clk_hf/8)
//   half_t       : half-period field type
package clk_div_prog_pkg;

  localparam int unsigned CDP_DIV_W    = 8;
  localparam int unsigned CDP_RST_HALF = 3;

  typedef logic [CDP_DIV_W-1:0] half_t;

endpackage : clk_div_prog_pkg

// File: rtl/clk_div_prog.sv
// Runtime-programmable glitch-free clock divider clocked from the PLL output.
// Ports:
//   clk_hf       in   PLL clock, the only clock of this block
//   rst_n        in   async active-low reset
//   div_req      in   single-cycle request to load div_val
//   div_val      in   requested half-period minus one (H); period = 2*(H+1)
//   div_ack      out  one-cycle pulse when the requested value takes effect
//   div_busy     out  high from request accept until div_ack
//   div_cur      out  half-period value currently in use
//   clk          out  divided clock, straight from a flop
//   clk_rise_en  out  first clk_hf cycle of each clk high phase
//   clk_fall_en  out  first clk_hf cycle of each clk low phase
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned DIV_W    = CDP_DIV_W,
  parameter int unsigned RST_HALF = CDP_RST_HALF
) (
  input  logic             clk_hf,
  input  logic             rst_n,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_busy,
  output logic [DIV_W-1:0] div_cur,
  output logic             clk,
  output logic             clk_rise_en,
  output logic             clk_fall_en
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] pend;
  logic             tc_c;
  logic             apply_c;
  logic             accept_c;

  // Terminal count ends the current phase.
  assign tc_c     = (count == div_cur);
  // New ratio only lands at the end of a high phase, so no phase is shortened.
  assign apply_c  = tc_c & clk & div_busy;
  // A request while busy is dropped; the requester waits for div_ack.
  assign accept_c = div_req & ~div_busy;

  // Phase counter, clock flop and edge strobes.
  always_ff @(posedge clk_hf or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      clk         <= 1'b0;
      clk_rise_en <= 1'b0;
      clk_fall_en <= 1'b0;
    end else begin
      if (tc_c) begin
        count <= '0;
        clk   <= ~clk;
      end else begin
        count <= count + DIV_W'(1);
      end
      clk_rise_en <= tc_c & ~clk;
      clk_fall_en <= tc_c & clk;
    end
  end

  // Request capture and apply handshake. Apply needs busy already set, so a
  // request captured on a falling boundary waits for the next one.
  always_ff @(posedge clk_hf or negedge rst_n) begin
    if (!rst_n) begin
      div_cur  <= DIV_W'(RST_HALF);
      pend     <= '0;
      div_busy <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      if (apply_c) begin
        div_cur  <= pend;
        div_busy <= 1'b0;
        div_ack  <= 1'b1;
      end
      if (accept_c) begin
        pend     <= div_val;
        div_busy <= 1'b1;
      end
    end
  end

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// Directed and random bench for clk_div_prog.
module tb_clk_div_prog;

  logic       clk_hf;
  logic       rst_n;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       div_busy;
  logic [7:0] div_cur;
  logic       clk;
  logic       clk_rise_en;
  logic       clk_fall_en;

  int n_chk  = 0;
  int n_fail = 0;

  clk_div_prog dut (
    .clk_hf      (clk_hf),
    .rst_n       (rst_n),
    .div_req     (div_req),
    .div_val     (div_val),
    .div_ack     (div_ack),
    .div_busy    (div_busy),
    .div_cur     (div_cur),
    .clk         (clk),
    .clk_rise_en (clk_rise_en),
    .clk_fall_en (clk_fall_en)
  );

  initial clk_hf = 1'b0;
  always #5 clk_hf = ~clk_hf;

  typedef struct {
    logic [7:0] val;  // requested half-period
    int         w;    // cycles after falling boundary before req is driven
    int         lat;  // expected cycles from req cycle to ack cycle
  } vec_t;

  vec_t tbl[5];

  // random-stream scoreboard state
  int         exp_cur;
  int         pend_val;
  bit         outstanding;
  int         acc_cnt;
  int         ack_cnt;
  int         ph_len;
  int         ph_exp;
  logic       prev_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_hf);
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    while (!clk_fall_en && n < 100) begin
      step();
      n++;
    end
    chk("sync_fall", int'(clk_fall_en), 1);
  endtask

  // Releases reset and checks the first two periods edge by edge.
  task automatic chk_release();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("rel_clk",  int'(clk),         (k / 4) % 2);
      chk("rel_rise", int'(clk_rise_en), int'(k % 8 == 4));
      chk("rel_fall", int'(clk_fall_en), int'(k % 8 == 0));
      chk("rel_ack",  int'(div_ack),     0);
    end
    chk("rel_busy", int'(div_busy), 0);
    chk("rel_cur",  int'(div_cur),  3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk"},  int'(clk),         0);
    chk({tag, "_busy"}, int'(div_busy),    0);
    chk({tag, "_ack"},  int'(div_ack),     0);
    chk({tag, "_cur"},  int'(div_cur),     3);
    chk({tag, "_rise"}, int'(clk_rise_en), 0);
    chk({tag, "_fall"}, int'(clk_fall_en), 0);
  endtask

  // One cycle of the random stream: drive, advance, score.
  task automatic rnd_cycle(input bit allow_req);
    bit changed;
    if (allow_req && ($urandom_range(0, 7) == 0)) begin
      div_req = 1'b1;
      div_val = 8'($urandom_range(0, 6));
      if (!outstanding) begin
        outstanding = 1'b1;
        pend_val    = int'(div_val);
        acc_cnt++;
      end
    end else begin
      div_req = 1'b0;
    end
    step();
    changed = (clk !== prev_clk);
    if (changed) chk("rnd_phase_len", ph_len, ph_exp);
    if (div_ack) begin
      ack_cnt++;
      chk("rnd_ack_on_fall", int'(changed && !clk), 1);
      exp_cur     = pend_val;
      outstanding = 1'b0;
    end
    if (changed) begin
      chk("rnd_cur", int'(div_cur), exp_cur);
      ph_exp = exp_cur + 1;
      ph_len = 1;
    end else begin
      ph_len++;
    end
    chk("rnd_rise", int'(clk_rise_en), int'(changed && clk));
    chk("rnd_fall", int'(clk_fall_en), int'(changed && !clk));
    chk("rnd_busy", int'(div_busy), int'(outstanding));
    prev_clk = clk;
  endtask

  initial begin
    int lat;
    int n;
    int acks;

    tbl[0] = '{val: 8'd9, w: 0,  lat: 8};
    tbl[1] = '{val: 8'd0, w: 14, lat: 6};
    tbl[2] = '{val: 8'd2, w: 1,  lat: 3};
    tbl[3] = '{val: 8'd2, w: 2,  lat: 4};
    tbl[4] = '{val: 8'd3, w: 0,  lat: 6};

    rst_n   = 1'b0;
    div_req = 1'b0;
    div_val = '0;

    // reset state and first periods
    step();
    step();
    chk_reset_vals("rst");
    chk_release();

    // table-driven ratio changes
    wait_fall();
    for (int i = 0; i < 5; i++) begin
      repeat (tbl[i].w) step();
      div_req = 1'b1;
      div_val = tbl[i].val;
      step();
      div_req = 1'b0;
      div_val = '0;
      lat = 1;
      chk("tbl_busy", int'(div_busy), 1);
      while (!div_ack && lat < 100) begin
        step();
        lat++;
      end
      chk("tbl_lat",      lat,               tbl[i].lat);
      chk("tbl_ack_fall", int'(clk_fall_en), 1);
      chk("tbl_cur",      int'(div_cur),     int'(tbl[i].val));
      chk("tbl_busy_clr", int'(div_busy),    0);
      n = 0;
      do begin
        step();
        n++;
      end while (!clk && n < 100);
      chk("tbl_low_len", n, int'(tbl[i].val) + 1);
      chk("tbl_rise",    int'(clk_rise_en), 1);
      n = 0;
      do begin
        step();
        n++;
      end while (clk && n < 100);
      chk("tbl_high_len", n, int'(tbl[i].val) + 1);
      chk("tbl_fall",     int'(clk_fall_en), 1);
    end

    // second request while busy is ignored
    div_req = 1'b1;
    div_val = 8'd5;
    step();
    div_req = 1'b0;
    step();
    div_req = 1'b1;
    div_val = 8'd1;
    step();
    div_req = 1'b0;
    div_val = '0;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (div_ack) acks++;
    end
    chk("busy_ign_acks", acks, 1);
    chk("busy_ign_cur",  int'(div_cur), 5);

    // reset in the middle of a change
    wait_fall();
    div_req = 1'b1;
    div_val = 8'd7;
    step();
    div_req = 1'b0;
    div_val = '0;
    step();
    chk("mid_busy", int'(div_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    step();
    chk_release();
    acks = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (div_ack) acks++;
    end
    chk("mid_no_ack", acks, 0);
    chk("mid_cur",    int'(div_cur), 3);

    // random request stream with phase-length scoreboard
    wait_fall();
    exp_cur     = 3;
    outstanding = 1'b0;
    acc_cnt     = 0;
    ack_cnt     = 0;
    ph_len      = 1;
    ph_exp      = 4;
    prev_clk    = clk;
    for (int k = 0; k < 10000; k++) rnd_cycle(1'b1);
    for (int k = 0; k < 40; k++) rnd_cycle(1'b0);
    chk("rnd_ack_count", ack_cnt, acc_cnt);
    chk("rnd_drained",   int'(outstanding), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_clk_div_prog
